// File: rtl/ltssm_timer_pkg.sv
// Shared types and the timeout-select decode for the LTSSM timer bank.
package ltssm_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    SEL_12MS      = 3'd0,
    SEL_24MS      = 3'd1,
    SEL_2MS       = 3'd2,
    SEL_48MS      = 3'd3,
    SEL_1MS       = 3'd4,
    SEL_100MS     = 3'd5,
    SEL_RAW_SPEED = 3'd6,
    SEL_RSVD      = 3'd7
  } tmo_sel_e;

  localparam int unsigned RAW_SPEED_CYCLES = 800;
  localparam int unsigned LIMIT_WIDTH      = 32;

  // Timeout length in clock cycles. The caller truncates to its counter width,
  // which the top checks at elaboration is wide enough for the 100 ms entry.
  function automatic logic [LIMIT_WIDTH-1:0] sel_to_limit(
    input logic [2:0]  sel,
    input int unsigned cycles_per_ms
  );
    int unsigned ms;
    logic        raw;
    ms  = 2;
    raw = 1'b0;
    case (tmo_sel_e'(sel))
      SEL_12MS:      ms = 12;
      SEL_24MS:      ms = 24;
      SEL_2MS:       ms = 2;
      SEL_48MS:      ms = 48;
      SEL_1MS:       ms = 1;
      SEL_100MS:     ms = 100;
      SEL_RAW_SPEED: raw = 1'b1;
      default:       ms = 2;  // reserved code behaves as the 2 ms timeout
    endcase
    if (raw) begin
      return LIMIT_WIDTH'(RAW_SPEED_CYCLES);
    end
    return LIMIT_WIDTH'(ms * cycles_per_ms);
  endfunction

endpackage

// File: rtl/ltssm_timer_ch.sv
// One independent timeout channel: up-counter compared against the latched limit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | not timing; count and chk hold their last values
// ST_RUN     | counting toward limit-1; pause freezes everything
// ST_EXPIRED | limit reached; timeout asserted until start or stop
module ltssm_timer_ch
  import ltssm_timer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_MS = 1024,
  parameter int unsigned CNT_WIDTH     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [2:0] sel,
  input  logic       chk_en,
  output logic       timeout,
  output logic       chk,
  output logic       busy
);

  localparam logic [CNT_WIDTH-1:0] CHK_POINT = CNT_WIDTH'(CYCLES_PER_MS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_MS    = CNT_WIDTH'(CYCLES_PER_MS);

  ch_state_e              state, state_n;
  logic [CNT_WIDTH-1:0]   count, count_n;
  logic                   chk_n;
  logic [2:0]             sel_q;
  logic                   chk_en_q;
  logic [CNT_WIDTH-1:0]   limit;
  logic [CNT_WIDTH-1:0]   last;

  assign limit = CNT_WIDTH'(sel_to_limit(sel_q, CYCLES_PER_MS));
  assign last  = limit - CNT_WIDTH'(1);

  // Latch the timeout select and checkpoint enable only on a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 3'd0;
      chk_en_q <= 1'b0;
    end else if (start) begin
      sel_q    <= sel;
      chk_en_q <= chk_en;
    end
  end

  // State, counter and sticky checkpoint registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      chk   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      chk   <= chk_n;
    end
  end

  // Next state: start beats stop; pause freezes RUN, including on the expiry edge.
  always_comb begin
    state_n = state;
    count_n = count;
    chk_n   = chk;
    if (start) begin
      state_n = ST_RUN;
      count_n = '0;
      chk_n   = 1'b0;
    end else if (stop) begin
      state_n = ST_IDLE;
    end else if (state == ST_RUN && !pause) begin
      if (count == last) begin
        state_n = ST_EXPIRED;
      end else begin
        count_n = count + CNT_WIDTH'(1);
      end
      // A timeout no longer than 1 ms expires before a checkpoint is meaningful.
      if (chk_en_q && count == CHK_POINT && limit > ONE_MS) begin
        chk_n = 1'b1;
      end
    end
  end

  assign timeout = (state == ST_EXPIRED);
  assign busy    = (state == ST_RUN);

endmodule

// File: rtl/ltssm_timer_bank.sv
// Bank of independent LTSSM timeout channels; each port bit/slice maps to one channel.
module ltssm_timer_bank
  import ltssm_timer_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CYCLES_PER_MS = 1024,
  parameter int unsigned CNT_WIDTH     = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      start,
  input  logic [NUM_CH-1:0]      stop,
  input  logic [NUM_CH-1:0]      pause,
  input  logic [NUM_CH-1:0][2:0] sel,
  input  logic [NUM_CH-1:0]      chk_en,
  output logic [NUM_CH-1:0]      timeout,
  output logic [NUM_CH-1:0]      chk,
  output logic [NUM_CH-1:0]      busy
);

  // The counter must reach the longest (100 ms) limit minus one.
  if ((longint'(100) * longint'(CYCLES_PER_MS)) - 1 > (longint'(1) << CNT_WIDTH) - 1) begin : g_bad_width
    $error("ltssm_timer_bank: CNT_WIDTH too small for 100*CYCLES_PER_MS-1");
  end

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("ltssm_timer_bank: NUM_CH must be 1..16");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ltssm_timer_ch #(
      .CYCLES_PER_MS (CYCLES_PER_MS),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .stop    (stop[i]),
      .pause   (pause[i]),
      .sel     (sel[i]),
      .chk_en  (chk_en[i]),
      .timeout (timeout[i]),
      .chk     (chk[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_ltssm_timer_bank.sv
// Directed bench for ltssm_timer_bank with a 16-cycle millisecond.
module tb_ltssm_timer_bank;

  localparam int NUM_CH = 4;
  localparam int CPM    = 16;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH-1:0]      start;
  logic [NUM_CH-1:0]      stop;
  logic [NUM_CH-1:0]      pause;
  logic [NUM_CH-1:0][2:0] sel;
  logic [NUM_CH-1:0]      chk_en;
  logic [NUM_CH-1:0]      timeout;
  logic [NUM_CH-1:0]      chk;
  logic [NUM_CH-1:0]      busy;

  int checks   = 0;
  int failures = 0;
  int busy_cnt;

  ltssm_timer_bank #(
    .NUM_CH        (NUM_CH),
    .CYCLES_PER_MS (CPM),
    .CNT_WIDTH     (17)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .sel     (sel),
    .chk_en  (chk_en),
    .timeout (timeout),
    .chk     (chk),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one channel: start is sampled on the next edge (E0), then released.
  task automatic pulse_start(input int ch, input logic [2:0] s, input logic ce);
    start[ch]  = 1'b1;
    sel[ch]    = s;
    chk_en[ch] = ce;
    step(1);
    start[ch]  = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = '0;
    stop   = '0;
    pause  = '0;
    sel    = '0;
    chk_en = '0;
    step(2);
    rst = 1'b0;
    check("reset_timeout", 32'(timeout), 32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_chk",     32'(chk),     32'h0);

    // Reset mid-count on ch0 (sel 0, chk already set at count 16).
    pulse_start(0, 3'd0, 1'b1);
    step(20);
    check("midrst_busy_before", 32'(busy[0]), 32'h1);
    check("midrst_chk_before",  32'(chk[0]),  32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_timeout", 32'(timeout[0]), 32'h0);
    check("midrst_busy",    32'(busy[0]),    32'h0);
    check("midrst_chk",     32'(chk[0]),     32'h0);
    step(200);
    check("midrst_no_expiry", 32'(timeout[0]), 32'h0);
    check("midrst_still_idle", 32'(busy[0]),   32'h0);

    // ch0 sel 2 (32 cycles), no checkpoint enable.
    pulse_start(0, 3'd2, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) busy_cnt++;
      step(1);
    end
    check("sel2_busy_cycles", 32'(busy_cnt),   32'd32);
    check("sel2_timeout",     32'(timeout[0]), 32'h1);
    check("sel2_no_chk",      32'(chk[0]),     32'h0);

    // ch1 sel 0 with checkpoint, paused 5 cycles at count 10.
    pulse_start(1, 3'd0, 1'b1);
    step(10);
    pause[1] = 1'b1;
    step(5);
    pause[1] = 1'b0;
    step(5);
    check("ch1_chk_e20", 32'(chk[1]), 32'h0);
    step(1);
    check("ch1_chk_e21", 32'(chk[1]), 32'h1);
    step(175);
    check("ch1_timeout_e196", 32'(timeout[1]), 32'h0);
    check("ch1_busy_e196",    32'(busy[1]),    32'h1);
    step(1);
    check("ch1_timeout_e197", 32'(timeout[1]), 32'h1);
    check("ch1_busy_e197",    32'(busy[1]),    32'h0);
    check("ch0_still_expired", 32'(timeout[0]), 32'h1);

    // ch2 raw 800 cycles and ch3 48 ms (768) run together.
    start[2] = 1'b1; sel[2] = 3'd6; chk_en[2] = 1'b0;
    start[3] = 1'b1; sel[3] = 3'd3; chk_en[3] = 1'b0;
    step(1);
    start[2] = 1'b0;
    start[3] = 1'b0;
    step(767);
    check("ch3_timeout_e767", 32'(timeout[3]), 32'h0);
    step(1);
    check("ch3_timeout_e768", 32'(timeout[3]), 32'h1);
    check("ch2_busy_e768",    32'(busy[2]),    32'h1);
    step(31);
    check("ch2_timeout_e799", 32'(timeout[2]), 32'h0);
    step(1);
    check("ch2_timeout_e800", 32'(timeout[2]), 32'h1);
    start[2] = 1'b1;
    stop[2]  = 1'b1;
    step(1);
    start[2] = 1'b0;
    stop[2]  = 1'b0;
    check("ch2_startstop_busy",    32'(busy[2]),    32'h1);
    check("ch2_startstop_timeout", 32'(timeout[2]), 32'h0);
    stop[2] = 1'b1;
    step(1);
    stop[2] = 1'b0;
    check("ch2_stop_busy", 32'(busy[2]), 32'h0);
    check("ch3_unaffected", 32'(timeout[3]), 32'h1);

    // Restart ch0 at count 20, then stop on the expiry edge.
    pulse_start(0, 3'd2, 1'b0);
    step(20);
    pulse_start(0, 3'd2, 1'b0);
    check("restart_busy", 32'(busy[0]), 32'h1);
    step(31);
    check("restart_busy_e31",    32'(busy[0]),    32'h1);
    check("restart_timeout_e31", 32'(timeout[0]), 32'h0);
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    check("stop_on_expiry_busy",    32'(busy[0]),    32'h0);
    check("stop_on_expiry_timeout", 32'(timeout[0]), 32'h0);
    step(5);
    check("stop_on_expiry_later", 32'(timeout[0]), 32'h0);

    // Pause on the expiry edge defers expiry by one cycle.
    pulse_start(1, 3'd2, 1'b0);
    step(31);
    pause[1] = 1'b1;
    step(1);
    pause[1] = 1'b0;
    check("pause_expiry_timeout", 32'(timeout[1]), 32'h0);
    check("pause_expiry_busy",    32'(busy[1]),    32'h1);
    step(1);
    check("pause_expiry_late", 32'(timeout[1]), 32'h1);

    // Reserved sel 7 acts as 2 ms; later sel/chk_en changes are ignored.
    pulse_start(1, 3'd7, 1'b1);
    sel[1]    = 3'd5;
    chk_en[1] = 1'b0;
    step(31);
    check("sel7_timeout_e31", 32'(timeout[1]), 32'h0);
    step(1);
    check("sel7_timeout_e32", 32'(timeout[1]), 32'h1);
    check("sel7_chk_latched", 32'(chk[1]),     32'h1);

    // sel 4 (1 ms) with checkpoint enabled: expiry at 16, chk never sets.
    pulse_start(2, 3'd4, 1'b1);
    step(15);
    check("sel4_timeout_e15", 32'(timeout[2]), 32'h0);
    check("sel4_chk_e15",     32'(chk[2]),     32'h0);
    step(1);
    check("sel4_timeout_e16", 32'(timeout[2]), 32'h1);
    check("sel4_chk_e16",     32'(chk[2]),     32'h0);
    step(3);
    check("sel4_chk_later", 32'(chk[2]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
